// File: rtl/jk_drv_pkg.sv
// Shared constants for the JK excitation driver: FSM state codes, JK input codes
// and the next-state function of a JK flip-flop.
package jk_drv_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRIVE = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   // JK codes are packed as {J, K}
   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] RST  = 2'b01;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] TOG  = 2'b11;

   function automatic logic jk_apply(input logic q, input logic [1:0] code);
      logic q_new;
      case (code)
         HOLD:    q_new = q;
         RST:     q_new = 1'b0;
         SET:     q_new = 1'b1;
         TOG:     q_new = ~q;
         default: q_new = q;
      endcase
      return q_new;
   endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// Target handshake, JK bank drive/feedback and status signals of jk_excite_driver.
interface jk_excite_driver_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_data;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] qn_fb;
   logic             done;
   logic             match;
   logic             err;
   logic [CNT_W-1:0] err_cnt;

   // master: target source plus the flip-flop bank it loads
   modport master (
      output tgt_valid, tgt_data, q_fb, qn_fb,
      input  tgt_ready, j, k, done, match, err, err_cnt
   );

   modport slave (
      input  tgt_valid, tgt_data, q_fb, qn_fb,
      output tgt_ready, j, k, done, match, err, err_cnt
   );
endinterface

// File: rtl/jk_excite.sv
// Minimal-switching JK excitation: toggle bits that differ from target, hold the rest.
module jk_excite
   import jk_drv_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] tgt,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k
);
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [1:0] code;
         // SET/RST are never needed: toggling a mismatched bit reaches the target
         assign code  = (q[gi] != tgt[gi]) ? TOG : HOLD;
         assign j[gi] = code[1];
         assign k[gi] = code[0];
      end
   endgenerate
endmodule

// File: rtl/jk_ff.sv
// Single JK flip-flop with complementary output; used as the driven load.
module jk_ff
   import jk_drv_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qn
);
   logic q_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_reg <= 1'b0;
      end else begin
         q_reg <= jk_apply(q_reg, {j, k});
      end
   end

   assign q  = q_reg;
   assign qn = ~q_reg;
endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flip-flop bank to requested target vectors and checks q/qn afterwards.
module jk_excite_driver
   import jk_drv_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input logic               clk,
   input logic               rst_n,
   jk_excite_driver_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] tgt_reg;
   logic [WIDTH-1:0] j_reg, k_reg;
   logic             done_reg, match_reg, err_reg;
   logic [CNT_W-1:0] err_cnt_reg;
   logic [WIDTH-1:0] exc_j, exc_k;
   logic             check_ok;
   logic             ready;

   jk_excite #(.WIDTH(WIDTH)) u_excite (
      .q   (bus.q_fb),
      .tgt (bus.tgt_data),
      .j   (exc_j),
      .k   (exc_k)
   );

   assign check_ok = (bus.q_fb == tgt_reg) && (bus.qn_fb == ~bus.q_fb);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.tgt_valid) state_next = DRIVE;
         DRIVE:   state_next = CHECK;
         CHECK:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready = (state_reg == IDLE);
   end

   // Excitation is loaded at acceptance so the bank sees it for the whole DRIVE cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tgt_reg     <= '0;
         j_reg       <= '0;
         k_reg       <= '0;
         done_reg    <= 1'b0;
         match_reg   <= 1'b0;
         err_reg     <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         done_reg  <= 1'b0;
         match_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.tgt_valid) begin
                  tgt_reg <= bus.tgt_data;
                  j_reg   <= exc_j;
                  k_reg   <= exc_k;
               end
            end
            DRIVE: begin
               j_reg <= '0;
               k_reg <= '0;
            end
            CHECK: begin
               done_reg  <= 1'b1;
               match_reg <= check_ok;
               if (!check_ok) begin
                  err_reg <= 1'b1;
                  if (err_cnt_reg != CNT_MAX) err_cnt_reg <= err_cnt_reg + 1'b1;
               end
            end
            default: begin
               j_reg <= '0;
               k_reg <= '0;
            end
         endcase
      end
   end

   assign bus.tgt_ready = ready;
   assign bus.j         = j_reg;
   assign bus.k         = k_reg;
   assign bus.done      = done_reg;
   assign bus.match     = match_reg;
   assign bus.err       = err_reg;
   assign bus.err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: JK bank load, behavioural bank model and done scoreboard.
module tb_jk_excite_driver;
   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic [WIDTH-1:0] jk;
      logic [WIDTH-1:0] qfb;
      logic [WIDTH-1:0] qn;
      logic             match;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bank_rst_n = 1'b0;
   logic [WIDTH-1:0] stuck = '0;
   logic [WIDTH-1:0] bank_q, bank_qn;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   exp_t exp_q[$];
   logic [WIDTH-1:0] model_q = '0;
   logic [WIDTH-1:0] last_jk = '0;
   logic [CNT_W-1:0] exp_cnt = '0;
   logic             exp_err = 1'b0;

   jk_excite_driver_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   jk_excite_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bank
         jk_ff u_ff (
            .clk   (clk),
            .rst_n (bank_rst_n),
            .j     (bus.j[gi]),
            .k     (bus.k[gi]),
            .q     (bank_q[gi]),
            .qn    (bank_qn[gi])
         );
      end
   endgenerate

   assign bus.q_fb  = bank_q & ~stuck;
   assign bus.qn_fb = bank_qn;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Scoreboard: every done pulse must match the oldest outstanding target
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         exp_t e;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done t=%0t match=%b q_fb=%h", $time, bus.match, bus.q_fb);
         end else begin
            e = exp_q.pop_front();
            if (bus.match !== e.match || bus.q_fb !== e.qfb || bus.qn_fb !== e.qn) begin
               n_bad++;
               $display("FAIL done_result t=%0t got match=%b q=%h qn=%h want match=%b q=%h qn=%h",
                        $time, bus.match, bus.q_fb, bus.qn_fb, e.match, e.qfb, e.qn);
            end else begin
               $display("done t=%0t match=%b q=%h qn=%h", $time, bus.match, bus.q_fb, bus.qn_fb);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge of the DRIVE cycle
   task automatic send(input logic [WIDTH-1:0] tgt, input bit keep, output int acc_cyc);
      int   n = 0;
      exp_t e;
      logic [WIDTH-1:0] fb;
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = tgt;
      acc_cyc = -1;
      while (bus.tgt_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.tgt_ready !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout tgt=%h ready=%b want 1", tgt, bus.tgt_ready);
      end else begin
         fb       = model_q & ~stuck;
         e.jk     = fb ^ tgt;
         model_q  = model_q ^ e.jk;
         e.qfb    = model_q & ~stuck;
         e.qn     = ~model_q;
         e.match  = (e.qfb == tgt) && (e.qn == ~e.qfb);
         if (!e.match) begin
            exp_err = 1'b1;
            if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
         end
         last_jk = e.jk;
         acc_cyc = cyc;
         exp_q.push_back(e);
         $display("send tgt=%h jk=%h exp_match=%b", tgt, e.jk, e.match);
      end
      @(negedge clk);
      if (!keep) bus.tgt_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = '0;
      rst_n = 1'b0;
      bank_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.j !== 4'h0 || bus.k !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_jk got j=%h k=%h want 0/0", bus.j, bus.k);
      end
      n_cmp++;
      if (bus.tgt_ready !== 1'b1 || bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl got ready=%b done=%b want 1/0", bus.tgt_ready, bus.done);
      end
      n_cmp++;
      if (bus.err !== 1'b0 || bus.err_cnt !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_err got err=%b cnt=%h want 0/00", bus.err, bus.err_cnt);
      end
      $display("reset checked");
      rst_n = 1'b1;
      bank_rst_n = 1'b1;
      model_q = '0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int a;
      send(4'hA, 1'b0, a);
      n_cmp++;
      if (bus.j !== 4'hA || bus.k !== 4'hA) begin
         n_bad++;
         $display("FAIL single_drive_jk got j=%h k=%h want A/A", bus.j, bus.k);
      end
      drain();
      n_cmp++;
      if (bus.q_fb !== 4'hA || bus.qn_fb !== 4'h5) begin
         n_bad++;
         $display("FAIL single_bank got q=%h qn=%h want A/5", bus.q_fb, bus.qn_fb);
      end
   endtask

   task automatic test_hold();
      int a;
      send(4'hA, 1'b0, a);
      n_cmp++;
      if (bus.j !== 4'h0 || bus.k !== 4'h0) begin
         n_bad++;
         $display("FAIL hold_drive_jk got j=%h k=%h want 0/0", bus.j, bus.k);
      end
      drain();
      n_cmp++;
      if (bus.q_fb !== 4'hA) begin
         n_bad++;
         $display("FAIL hold_bank got q=%h want A", bus.q_fb);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] tv[3];
      int acc[3];
      tv[0] = 4'hF; tv[1] = 4'h3; tv[2] = 4'hC;
      for (int i = 0; i < 3; i++) begin
         send(tv[i], (i < 2), acc[i]);
         n_cmp++;
         if (bus.tgt_ready !== 1'b0 || bus.j !== last_jk || bus.k !== last_jk) begin
            n_bad++;
            $display("FAIL b2b_drive%0d got ready=%b j=%h k=%h want 0/%h/%h",
                     i, bus.tgt_ready, bus.j, bus.k, last_jk, last_jk);
         end
         if (i > 0) begin
            n_cmp++;
            if (acc[i] - acc[i-1] != 3) begin
               n_bad++;
               $display("FAIL b2b_spacing%0d got %0d cycles want 3", i, acc[i] - acc[i-1]);
            end
         end
      end
      drain();
   endtask

   task automatic test_stuck();
      int a;
      stuck = 4'h1;
      send(4'h1, 1'b0, a);
      drain();
      n_cmp++;
      if (bus.err !== 1'b1 || bus.err_cnt !== exp_cnt) begin
         n_bad++;
         $display("FAIL stuck_first got err=%b cnt=%h want 1/%h", bus.err, bus.err_cnt, exp_cnt);
      end
      for (int i = 0; i < 299; i++) begin
         send(4'h1, 1'b0, a);
         drain();
      end
      n_cmp++;
      if (bus.err !== exp_err || bus.err_cnt !== exp_cnt || exp_cnt !== 8'hFF) begin
         n_bad++;
         $display("FAIL stuck_saturate got err=%b cnt=%h want %b/%h", bus.err, bus.err_cnt, exp_err, exp_cnt);
      end
      stuck = 4'h0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int a;
      send(model_q ^ 4'h5, 1'b0, a);
      n_cmp++;
      if (bus.j !== 4'h5 || bus.k !== 4'h5) begin
         n_bad++;
         $display("FAIL rstmid_drive_jk got j=%h k=%h want 5/5", bus.j, bus.k);
      end
      rst_n = 1'b0;
      @(negedge clk);
      exp_q.delete();
      exp_cnt = '0;
      exp_err = 1'b0;
      n_cmp++;
      if (bus.j !== 4'h0 || bus.k !== 4'h0 || bus.tgt_ready !== 1'b1 || bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_state got j=%h k=%h ready=%b done=%b want 0/0/1/0",
                  bus.j, bus.k, bus.tgt_ready, bus.done);
      end
      n_cmp++;
      if (bus.err !== 1'b0 || bus.err_cnt !== 8'h00) begin
         n_bad++;
         $display("FAIL rstmid_err got err=%b cnt=%h want 0/00", bus.err, bus.err_cnt);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send(4'h6, 1'b0, a);
      drain();
      n_cmp++;
      if (bus.q_fb !== 4'h6 || bus.err !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_after got q=%h err=%b want 6/0", bus.q_fb, bus.err);
      end
   endtask

   initial begin
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_hold();
      test_back_to_back();
      test_stuck();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
